pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequencer for the five-stage pipeline registers (ID/EX/MEM/WB).
//  - Drives every stage's wr_en and gen_bubble, plus the fetch PC enable.
//  - Resolves load-use hazards, branch/jump redirects, I-fetch and D-mem wait stalls.
//  - Discards a fetch that was in flight when a redirect occurred.
//  - Sits beside the pipe regs; consumes decoded hazard fields from ID, EX and MEM.
// PARAMETERS
//  REG_W        5    register index width
//  HANG_LIMIT   1024 consecutive stalled cycles before hang_err asserts
//  CNT_W        32   perf counter width (only with PIPE_HAZARD_PERF_EN)
// PORTS
//  clk            in   1      clock
//  reset          in   1      asynchronous, active-high reset
//  id_valid       in   1      ID holds a real instruction (not a bubble)
//  id_rs1         in   REG_W  ID source reg 1
//  id_rs2         in   REG_W  ID source reg 2
//  id_use_rs1     in   1      ID reads rs1
//  id_use_rs2     in   1      ID reads rs2
//  ex_valid       in   1      EX holds a real instruction
//  ex_is_load     in   1      EX instruction is a load
//  ex_rd          in   REG_W  EX destination reg
//  ex_redirect    in   1      EX resolved taken branch/jump (PC change)
//  if_busy        in   1      I-fetch has not returned this cycle
//  mem_busy       in   1      D-mem access in MEM not complete
//  pc_en          out  1      advance/load fetch PC
//  id_wr_en       out  1      ID register write enable
//  id_gen_bubble  out  1      ID register captures a bubble
//  ex_wr_en       out  1      EX register write enable
//  ex_gen_bubble  out  1      EX register captures a bubble
//  mem_wr_en      out  1      MEM register write enable
//  mem_gen_bubble out  1      MEM register captures a bubble
//  wb_wr_en       out  1      WB register write enable
//  wb_gen_bubble  out  1      WB register captures a bubble
//  hang_err       out  1      sticky: stall persisted HANG_LIMIT cycles
// BEHAVIOUR
//  Reset (async): FSM=RUN; stall_cnt=0; hang_err=0; perf counters=0.
//  - All wr_en=1, all gen_bubble=1 while reset asserted, so every stage loads a bubble.
//  Combinational from inputs + state; 0-cycle latency.
//  Priority (highest first), evaluated every cycle:
//  1 mem_busy: all wr_en=0, pc_en=0 (full freeze); ex_redirect is ignored and re-seen later.
//  2 ex_redirect & ex_valid:
//    - pc_en=1; ID and EX load bubbles (wr_en=1, gen_bubble=1); MEM/WB advance normally.
//    - if if_busy, FSM->IDROP.
//  3 load-use: ex_valid & ex_is_load & ex_rd!=0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)):
//    - pc_en=0; id_wr_en=0; EX loads a bubble; MEM/WB advance.
//  4 if_busy or FSM=IDROP:
//    - pc_en=0; ID loads a bubble; EX/MEM/WB advance.
//  5 else: all wr_en=1, all gen_bubble=0, pc_en=1.
//  FSM:
//    RUN   -> IDROP on rule 2 with if_busy=1.
//    IDROP -> RUN on the first cycle with if_busy=0; that returning fetch is discarded (ID gets a bubble).
//    - In IDROP, pc_en=0 until the exit cycle; on the exit cycle pc_en=1.
//    - A second redirect while in IDROP keeps IDROP.
//  stall_cnt: +1 each cycle with pc_en=0, clears on pc_en=1, saturates at HANG_LIMIT.
//    - hang_err sets when stall_cnt==HANG_LIMIT; cleared only by reset.
//  rd==0 never causes a load-use stall.
// CONFIGURATION
//  PIPE_HAZARD_PERF_EN defined:
//    - adds outputs perf_lu_stalls, perf_flushes, perf_mem_stalls (CNT_W, wrapping).
//    - each counts cycles in which rules 3, 2 and 1 fire, respectively.
//  Undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared package pipe_pkg: hz_state_t enum {RUN, IDROP}; stage_ctl_t struct {wr_en, gen_bubble}.
//  Sub-module lu_detect: pure combinational load-use comparator (rules 3 terms).
// TESTING
//  1 Free run, all busy=0, no hazards -> every wr_en=1, gen_bubble=0, pc_en=1 each cycle.
//  2 EX: load to x5; ID: add reading rs1=x5 -> 1 cycle pc_en=0, id_wr_en=0, ex_gen_bubble=1; next cycle normal.
//  3 EX: load to x0; ID reads x0 -> no stall.
//  4 ex_redirect with if_busy=1 for 3 cycles -> ID/EX bubble; IDROP held 3 cycles; 4th cycle ID bubble + pc_en=1; then RUN.
//  5 mem_busy for 5 cycles concurrent with load-use and redirect -> all wr_en=0 for 5 cycles, then redirect is applied.
//  6 HANG_LIMIT=8, mem_busy held high -> hang_err=1 on cycle 9 and stays set; mid-stall reset -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Package pipe_pkg: types shared by the pipeline hazard sequencer.
//   hz_state_t  : fetch-discard FSM states (RUN, IDROP)
//   stage_ctl_t : per-stage pipe register control {wr_en, gen_bubble}
package pipe_pkg;

  typedef enum logic {
    RUN,
    IDROP
  } hz_state_t;

  typedef struct packed {
    logic wr_en;
    logic gen_bubble;
  } stage_ctl_t;

  localparam stage_ctl_t CTL_ADVANCE = '{wr_en: 1'b1, gen_bubble: 1'b0};
  localparam stage_ctl_t CTL_BUBBLE  = '{wr_en: 1'b1, gen_bubble: 1'b1};
  localparam stage_ctl_t CTL_HOLD    = '{wr_en: 1'b0, gen_bubble: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// lu_detect: combinational load-use hazard comparator.
//   Flags when the load in EX writes a register (other than x0) that the
//   valid instruction in ID reads.
// Ports:
//   id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2 : ID source operands
//   ex_valid, ex_is_load, ex_rd                      : EX producer
//   hazard                                           : load-use stall needed
module lu_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  output logic             hazard
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    hazard  = ex_valid && ex_is_load && (ex_rd != '0) && id_valid && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequencer for the ID/EX/MEM/WB pipe registers and fetch PC.
//   Priority: D-mem wait freeze > EX redirect flush > load-use stall >
//   I-fetch wait / stale-fetch discard > normal advance.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   id_*                  : decoded ID operand fields
//   ex_valid/ex_is_load/ex_rd/ex_redirect : EX producer and branch resolution
//   if_busy, mem_busy     : fetch / data-memory wait
//   pc_en                 : advance/load fetch PC
//   <stage>_wr_en/_gen_bubble : per-stage register controls
//   hang_err              : sticky, stall persisted HANG_LIMIT cycles
// Optional: `define PIPE_HAZARD_PERF_EN adds perf_lu_stalls, perf_flushes,
//   perf_mem_stalls (CNT_W-bit wrapping cycle counters).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned HANG_LIMIT = 1024,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic             if_busy,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             id_wr_en,
  output logic             id_gen_bubble,
  output logic             ex_wr_en,
  output logic             ex_gen_bubble,
  output logic             mem_wr_en,
  output logic             mem_gen_bubble,
  output logic             wb_wr_en,
  output logic             wb_gen_bubble,
  output logic             hang_err
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_lu_stalls,
  output logic [CNT_W-1:0] perf_flushes,
  output logic [CNT_W-1:0] perf_mem_stalls
`endif
);

  localparam int unsigned STALL_W = $clog2(HANG_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(HANG_LIMIT);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  hz_state_t        state, next_state;
  stage_ctl_t       id_ctl, ex_ctl, mem_ctl, wb_ctl;
  logic             lu_hazard;
  logic             redirect;
  logic [STALL_W-1:0] stall_cnt;
  logic             hang_q;

  lu_detect #(.REG_W(REG_W)) u_lu_detect (
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .hazard     (lu_hazard)
  );

  assign redirect = ex_redirect && ex_valid;

  // The FSM only moves on flush or fetch-wait cycles; a freeze or load-use
  // stall holds IDROP so a stale fetch returning under the stall is still
  // discarded once the pipe moves again.
  always_comb begin
    id_ctl     = CTL_ADVANCE;
    ex_ctl     = CTL_ADVANCE;
    mem_ctl    = CTL_ADVANCE;
    wb_ctl     = CTL_ADVANCE;
    pc_en      = 1'b1;
    next_state = state;
    if (reset) begin
      id_ctl  = CTL_BUBBLE;
      ex_ctl  = CTL_BUBBLE;
      mem_ctl = CTL_BUBBLE;
      wb_ctl  = CTL_BUBBLE;
      pc_en   = 1'b0;
    end else if (mem_busy) begin
      id_ctl  = CTL_HOLD;
      ex_ctl  = CTL_HOLD;
      mem_ctl = CTL_HOLD;
      wb_ctl  = CTL_HOLD;
      pc_en   = 1'b0;
    end else if (redirect) begin
      id_ctl = CTL_BUBBLE;
      ex_ctl = CTL_BUBBLE;
      if (if_busy || (state == IDROP)) next_state = IDROP;
    end else if (lu_hazard) begin
      id_ctl = CTL_HOLD;
      ex_ctl = CTL_BUBBLE;
      pc_en  = 1'b0;
    end else if (if_busy || (state == IDROP)) begin
      id_ctl = CTL_BUBBLE;
      pc_en  = (state == IDROP) && !if_busy;
      if ((state == IDROP) && !if_busy) next_state = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      stall_cnt <= '0;
      hang_q    <= 1'b0;
    end else begin
      state <= next_state;
      if (pc_en) stall_cnt <= '0;
      else if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + STALL_W'(1);
      if (stall_cnt == STALL_MAX) hang_q <= 1'b1;
    end
  end

  // Reported in the same cycle the count reaches the limit; the flop keeps it.
  assign hang_err = hang_q || (stall_cnt == STALL_MAX);

  assign id_wr_en       = id_ctl.wr_en;
  assign id_gen_bubble  = id_ctl.gen_bubble;
  assign ex_wr_en       = ex_ctl.wr_en;
  assign ex_gen_bubble  = ex_ctl.gen_bubble;
  assign mem_wr_en      = mem_ctl.wr_en;
  assign mem_gen_bubble = mem_ctl.gen_bubble;
  assign wb_wr_en       = wb_ctl.wr_en;
  assign wb_gen_bubble  = wb_ctl.gen_bubble;

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lu_stalls  <= '0;
      perf_flushes    <= '0;
      perf_mem_stalls <= '0;
    end else begin
      if (mem_busy) perf_mem_stalls <= perf_mem_stalls + CNT_W'(1);
      if (!mem_busy && redirect) perf_flushes <= perf_flushes + CNT_W'(1);
      if (!mem_busy && !redirect && lu_hazard) perf_lu_stalls <= perf_lu_stalls + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int HL = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       ex_valid = 1'b0, ex_is_load = 1'b0, ex_redirect = 1'b0;
  logic       if_busy = 1'b0, mem_busy = 1'b0;
  logic       pc_en, id_wr_en, id_gen_bubble, ex_wr_en, ex_gen_bubble;
  logic       mem_wr_en, mem_gen_bubble, wb_wr_en, wb_gen_bubble, hang_err;

  int n_cmp = 0;
  int n_fail = 0;

  // {pc_en, id wr/bub, ex wr/bub, mem wr/bub, wb wr/bub, hang_err}
  logic [9:0] obs;
  assign obs = {pc_en, id_wr_en, id_gen_bubble, ex_wr_en, ex_gen_bubble,
                mem_wr_en, mem_gen_bubble, wb_wr_en, wb_gen_bubble, hang_err};

  localparam logic [9:0] E_NORMAL = 10'b1_10_10_10_10_0;
  localparam logic [9:0] E_LU     = 10'b0_00_11_10_10_0;
  localparam logic [9:0] E_REDIR  = 10'b1_11_11_10_10_0;
  localparam logic [9:0] E_IFWAIT = 10'b0_11_10_10_10_0;
  localparam logic [9:0] E_IDEXIT = 10'b1_11_10_10_10_0;
  localparam logic [9:0] E_FREEZE = 10'b0_00_00_00_00_0;
  localparam logic [9:0] E_RESET  = 10'b0_11_11_11_11_0;

  pipe_hazard_ctrl #(.REG_W(5), .HANG_LIMIT(HL), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .if_busy(if_busy), .mem_busy(mem_busy),
    .pc_en(pc_en), .id_wr_en(id_wr_en), .id_gen_bubble(id_gen_bubble),
    .ex_wr_en(ex_wr_en), .ex_gen_bubble(ex_gen_bubble),
    .mem_wr_en(mem_wr_en), .mem_gen_bubble(mem_gen_bubble),
    .wb_wr_en(wb_wr_en), .wb_gen_bubble(wb_gen_bubble), .hang_err(hang_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic exv, input logic ld,
                       input logic [4:0] rd, input logic redir, input logic ifb, input logic memb);
    id_valid = idv; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_valid = exv; ex_is_load = ld; ex_rd = rd; ex_redirect = redir;
    if_busy = ifb; mem_busy = memb;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- reference model (rule table) ----------------
  bit m_drop;   // a redirected fetch is still owed a discard
  int m_stall;
  bit m_hang;

  function automatic int rule_now();
    bit lu;
    lu = ex_valid && ex_is_load && (ex_rd != 0) && id_valid &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (mem_busy) return 1;
    if (ex_redirect && ex_valid) return 2;
    if (lu) return 3;
    if (if_busy || m_drop) return 4;
    return 5;
  endfunction

  function automatic logic [9:0] model_out();
    logic [9:0] e;
    case (rule_now())
      1: e = E_FREEZE;
      2: e = E_REDIR;
      3: e = E_LU;
      4: e = (m_drop && !if_busy) ? E_IDEXIT : E_IFWAIT;
      default: e = E_NORMAL;
    endcase
    e[0] = m_hang || (m_stall == HL);
    return e;
  endfunction

  task automatic model_step();
    logic [9:0] e;
    int r;
    e = model_out();
    r = rule_now();
    if (m_stall == HL) m_hang = 1;
    m_stall = e[9] ? 0 : ((m_stall < HL) ? m_stall + 1 : HL);
    if (r == 2) m_drop = m_drop || if_busy;
    else if (r == 4 && m_drop && !if_busy) m_drop = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(1, 1, 2, 1, 1, 1, 0, 3, 0, 0, 0);
    #1;
    n_cmp++;
    if (obs !== E_RESET) begin
      n_fail++; $display("FAIL reset_hold: got %b want %b", obs, E_RESET);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== E_NORMAL) begin
      n_fail++; $display("FAIL reset_release: got %b want %b", obs, E_NORMAL);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 6; i++) begin
      drive(1, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 0, 5'($urandom), 0, 0, 0);
      @(negedge clk);
      n_cmp++;
      if (obs !== E_NORMAL) begin
        n_fail++; $display("FAIL free_run[%0d]: got %b want %b", i, obs, E_NORMAL);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    // load x5 in EX, ID reads x5 via rs1, then the bubble reaches EX
    drive(1, 5, 7, 1, 1, 1, 1, 5, 0, 0, 0);
    @(negedge clk); n_cmp++;
    if (obs !== E_LU) begin n_fail++; $display("FAIL lu_rs1: got %b want %b", obs, E_LU); end
    @(posedge clk); #1;
    drive(1, 5, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); n_cmp++;
    if (obs !== E_NORMAL) begin n_fail++; $display("FAIL lu_after: got %b want %b", obs, E_NORMAL); end
    @(posedge clk); #1;
    // match on rs2 only
    drive(1, 3, 9, 1, 1, 1, 1, 9, 0, 0, 0);
    @(negedge clk); n_cmp++;
    if (obs !== E_LU) begin n_fail++; $display("FAIL lu_rs2: got %b want %b", obs, E_LU); end
    @(posedge clk); #1;
    // matching register but operand not used
    drive(1, 9, 4, 0, 1, 1, 1, 9, 0, 0, 0);
    @(negedge clk); n_cmp++;
    if (obs !== E_NORMAL) begin n_fail++; $display("FAIL lu_unused: got %b want %b", obs, E_NORMAL); end
    @(posedge clk); #1;
  endtask

  task automatic test_rd_zero();
    drive(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
    @(negedge clk); n_cmp++;
    if (obs !== E_NORMAL) begin n_fail++; $display("FAIL rd_zero: got %b want %b", obs, E_NORMAL); end
    @(posedge clk); #1;
  endtask

  task automatic test_redirect_idrop();
    logic [9:0] seq [6];
    seq = '{E_REDIR, E_IFWAIT, E_IFWAIT, E_IFWAIT, E_IDEXIT, E_NORMAL};
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 2, 1, 1, (i == 0), 0, 4, (i == 0), (i < 4), 0);
      @(negedge clk); n_cmp++;
      if (obs !== seq[i]) begin
        n_fail++; $display("FAIL redirect_idrop[%0d]: got %b want %b", i, obs, seq[i]);
      end
      @(posedge clk); #1;
    end
    // a second redirect while dropping keeps the discard pending
    seq = '{E_REDIR, E_REDIR, E_IDEXIT, E_NORMAL, E_NORMAL, E_NORMAL};
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 2, 1, 1, (i < 2), 0, 4, (i < 2), (i == 0), 0);
      @(negedge clk); n_cmp++;
      if (obs !== seq[i]) begin
        n_fail++; $display("FAIL redirect_twice[%0d]: got %b want %b", i, obs, seq[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_busy();
    for (int i = 0; i < 7; i++) begin
      logic [9:0] e;
      e = (i < 5) ? E_FREEZE : ((i == 5) ? E_REDIR : E_NORMAL);
      // load-use on x6 and a redirect both pending under the freeze
      drive(1, 6, 6, 1, 0, (i < 6), (i < 6), 6, (i < 6), 0, (i < 5));
      @(negedge clk); n_cmp++;
      if (obs !== e) begin
        n_fail++; $display("FAIL mem_busy[%0d]: got %b want %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    apply_reset();
    m_drop = 0; m_stall = 0; m_hang = 0;
    for (int i = 0; i < 400; i++) begin
      logic [9:0] e;
      drive(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      @(negedge clk);
      e = model_out();
      n_cmp++;
      if (obs !== e) begin
        n_fail++; $display("FAIL random[%0d]: got %b want %b", i, obs, e);
      end
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic test_hang();
    apply_reset();
    for (int c = 1; c <= 12; c++) begin
      logic [9:0] e;
      e = E_FREEZE;
      e[0] = (c >= HL + 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk); n_cmp++;
      if (obs !== e) begin
        n_fail++; $display("FAIL hang_cycle%0d: got %b want %b", c, obs, e);
      end
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); n_cmp++;
    if (obs !== (E_NORMAL | 10'b1)) begin
      n_fail++; $display("FAIL hang_sticky: got %b want %b", obs, E_NORMAL | 10'b1);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1; n_cmp++;
    if (obs !== E_RESET) begin
      n_fail++; $display("FAIL hang_mid_reset: got %b want %b", obs, E_RESET);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); n_cmp++;
    if (obs !== E_NORMAL) begin
      n_fail++; $display("FAIL hang_cleared: got %b want %b", obs, E_NORMAL);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load_use();
    test_rd_zero();
    test_redirect_idrop();
    test_mem_busy();
    test_random();
    test_hang();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
